parallel_packer: RTL

PARALLEL_PACKER -- requirements
Module: parallel_packer

---
 rtl/parallel_pkg.sv | 22 ++
 rtl/parallel_packer_if.sv | 32 +++
 rtl/packer_lane_buf.sv | 47 ++++
 rtl/parallel_packer.sv | 88 ++++++++
 4 files changed

// File: rtl/parallel_pkg.sv
// rtl/parallel_pkg.sv - shared lane-count helpers, default widths and output FSM states
package parallel_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_IN_PARALLELISM  = 32;
  localparam int DEF_OUT_PARALLELISM = 128;

  typedef enum logic {
    OUT_EMPTY   = 1'b0,
    OUT_PENDING = 1'b1
  } out_state_e;

  // Lane counts run 0..out_par inclusive, hence the extra bit.
  function automatic int lanes_width(input int out_par);
    return $clog2(out_par) + 1;
  endfunction

  function automatic int slot_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/parallel_packer_if.sv
// rtl/parallel_packer_if.sv - beat input and FIFO write bundle of the parallel packer
interface parallel_packer_if
  import parallel_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IN_PARALLELISM  = DEF_IN_PARALLELISM,
  parameter int OUT_PARALLELISM = DEF_OUT_PARALLELISM
) ();

  localparam int LANES_W = lanes_width(OUT_PARALLELISM);

  logic                                  in_valid;
  logic [IN_PARALLELISM*DATA_WIDTH-1:0]  in_data;
  logic                                  in_last;
  logic                                  in_ready;
  logic                                  full;
  logic                                  wr_en;
  logic [OUT_PARALLELISM*DATA_WIDTH-1:0] wr_data;
  logic [LANES_W-1:0]                    wr_lanes;
  logic [31:0]                           word_count;

  modport slave (
    input  in_valid, in_data, in_last, full,
    output in_ready, wr_en, wr_data, wr_lanes, word_count
  );

  modport master (
    output in_valid, in_data, in_last, full,
    input  in_ready, wr_en, wr_data, wr_lanes, word_count
  );

endinterface

// File: rtl/packer_lane_buf.sv
// rtl/packer_lane_buf.sv - assembly register and slot counter; presents the completed word on the completing beat
module packer_lane_buf
  import parallel_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IN_PARALLELISM  = DEF_IN_PARALLELISM,
  parameter int OUT_PARALLELISM = DEF_OUT_PARALLELISM,
  localparam int IN_W    = IN_PARALLELISM * DATA_WIDTH,
  localparam int OUT_W   = OUT_PARALLELISM * DATA_WIDTH,
  localparam int LANES_W = lanes_width(OUT_PARALLELISM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat_en,
  input  logic [IN_W-1:0]    beat_data,
  input  logic               beat_last,
  output logic               word_done,
  output logic [OUT_W-1:0]   word_data,
  output logic [LANES_W-1:0] word_lanes
);

  localparam int RATIO  = OUT_PARALLELISM / IN_PARALLELISM;
  localparam int SLOT_W = slot_width(RATIO);

  logic [SLOT_W-1:0] cnt_q;
  logic [OUT_W-1:0]  asm_q;

  assign word_done  = beat_en && ((cnt_q == SLOT_W'(RATIO - 1)) || beat_last);
  assign word_lanes = LANES_W'((32'(cnt_q) + 32'd1) * IN_PARALLELISM);

  // Unfilled slots of asm_q are always zero, so a partial word needs no masking.
  always_comb begin
    word_data = asm_q;
    word_data[32'(cnt_q) * IN_W +: IN_W] = beat_data;
  end

  always_ff @(posedge clk) begin
    if (rst || word_done) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (beat_en) begin
      cnt_q <= cnt_q + SLOT_W'(1);
      asm_q <= word_data;
    end
  end

endmodule

// File: rtl/parallel_packer.sv
// rtl/parallel_packer.sv - packs narrow input beats into wide FIFO words with a one-word output stage
module parallel_packer
  import parallel_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IN_PARALLELISM  = DEF_IN_PARALLELISM,
  parameter int OUT_PARALLELISM = DEF_OUT_PARALLELISM
) (
  input  logic               clk,
  input  logic               rst,
  parallel_packer_if.slave   bus
);

  localparam int OUT_W   = OUT_PARALLELISM * DATA_WIDTH;
  localparam int LANES_W = lanes_width(OUT_PARALLELISM);

  if ((OUT_PARALLELISM % IN_PARALLELISM) != 0 || (OUT_PARALLELISM / IN_PARALLELISM) < 2) begin : g_bad_ratio
    $error("parallel_packer: OUT_PARALLELISM must be a multiple >= 2 of IN_PARALLELISM");
  end

  out_state_e         state_q;
  out_state_e         state_d;
  logic               out_valid;
  logic               accept;
  logic               wr_fire;
  logic               word_done;
  logic [OUT_W-1:0]   word_data;
  logic [LANES_W-1:0] word_lanes;
  logic [OUT_W-1:0]   out_data_q;
  logic [LANES_W-1:0] out_lanes_q;
  logic [31:0]        count_q;

  assign out_valid = (state_q == OUT_PENDING);
  // A beat is only taken when the held word drains this same cycle, so it is never overwritten.
  assign bus.in_ready = !rst && !(out_valid && bus.full);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr_fire      = !rst && out_valid && !bus.full;

  assign bus.wr_en      = wr_fire;
  assign bus.wr_data    = out_data_q;
  assign bus.wr_lanes   = out_lanes_q;
  assign bus.word_count = count_q;

  packer_lane_buf #(
    .DATA_WIDTH      (DATA_WIDTH),
    .IN_PARALLELISM  (IN_PARALLELISM),
    .OUT_PARALLELISM (OUT_PARALLELISM)
  ) u_lane_buf (
    .clk        (clk),
    .rst        (rst),
    .beat_en    (accept),
    .beat_data  (bus.in_data),
    .beat_last  (bus.in_last),
    .word_done  (word_done),
    .word_data  (word_data),
    .word_lanes (word_lanes)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY:   if (word_done) state_d = OUT_PENDING;
      OUT_PENDING: if (wr_fire && !word_done) state_d = OUT_EMPTY;
      default:     state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_lanes_q <= '0;
    end else if (word_done) begin
      out_data_q  <= word_data;
      out_lanes_q <= word_lanes;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          count_q <= '0;
    else if (wr_fire) count_q <= count_q + 32'd1;
  end

endmodule
